// File: rtl/uart_apb_regs.sv
// uart_apb_regs
// APB3 slave register file for the UART subsystem.
//
// Register map (byte offsets, PADDR[4:0] decoded, word aligned):
//   0x00 DATA     : write pushes PWDATA[7:0] into TX FIFO, read pops RX FIFO
//   0x04 CTRL     : [0] en_sys [1] tx_en [3:2] clk_freq_index [6:4] baud_rate_index
//                   [7] spare, read/write, so software readback matches the written byte
//   0x08 STAT     : live status, read only
//   0x0C INT_STAT : write-1-to-clear, [0] rx_done [1] tx_done [2] rx_err [3] rx_thresh
//   0x10 INT_EN   : [3:0] interrupt mask
//   0x14 RX_THR   : [LVL_W-1:0] RX level threshold, reset 1
//
// Ports:
//   PCLK, PRESETn                       clock, async active-low reset
//   PADDR/PSELx/PENABLE/PWRITE/PWDATA   APB request
//   PREADY/PRDATA/PSLVERR               APB response
//   full_tx_fifo, tx_level              TX FIFO status
//   empty_rx_fifo, rx_level, dout_rx_fifo  RX FIFO status and show-ahead data
//   tx_busy/tx_ready/rx_busy/rx_ready/rx_error  engine status
//   din_tx_fifo, wr_en_tx_fifo          TX FIFO push
//   rd_en_rx_fifo                       RX FIFO pop
//   en_sys/tx_en/clk_freq_index/baud_rate_index  configuration
//   irq                                 registered level interrupt
//
// Optional feature macro: UART_APB_STALL_TIMEOUT_EN
//   When defined, a DATA write held off by a full TX FIFO is terminated with
//   PSLVERR after STALL_TIMEOUT stalled cycles and the write is dropped.
//   When undefined, PREADY stays low until the TX FIFO has room.

module uart_apb_regs #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int LVL_W         = 5,
  parameter int WAIT_CYCLES   = 0,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  input  logic                  full_tx_fifo,
  input  logic [LVL_W-1:0]      tx_level,
  input  logic                  empty_rx_fifo,
  input  logic [LVL_W-1:0]      rx_level,
  input  logic [7:0]            dout_rx_fifo,
  input  logic                  tx_busy,
  input  logic                  tx_ready,
  input  logic                  rx_busy,
  input  logic                  rx_ready,
  input  logic                  rx_error,
  output logic [7:0]            din_tx_fifo,
  output logic                  wr_en_tx_fifo,
  output logic                  rd_en_rx_fifo,
  output logic                  en_sys,
  output logic                  tx_en,
  output logic [1:0]            clk_freq_index,
  output logic [2:0]            baud_rate_index,
  output logic                  irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [4:0] A_DATA     = 5'h00;
  localparam logic [4:0] A_CTRL     = 5'h04;
  localparam logic [4:0] A_STAT     = 5'h08;
  localparam logic [4:0] A_INT_STAT = 5'h0C;
  localparam logic [4:0] A_INT_EN   = 5'h10;
  localparam logic [4:0] A_RX_THR   = 5'h14;

  logic [1:0]       state;
  logic [2:0]       wait_cnt;
  logic [7:0]       ctrl_q;
  logic [3:0]       int_stat_q;
  logic [3:0]       int_en_q;
  logic [LVL_W-1:0] rx_thr_q;
  logic             rx_ready_q;
  logic             tx_ready_q;
  logic             rx_error_q;
  logic             irq_q;

  logic [4:0]  addr;
  logic        is_data;
  logic        is_stat;
  logic        is_int_stat;
  logic        mapped;
  logic        data_wr;
  logic        in_access;
  logic        bus_phase;
  logic        stalled;
  logic        stall_timeout;
  logic        completion;
  logic        err_cond;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [31:0] stat_word;
  logic [3:0]  int_set;
  logic [3:0]  int_w1c;
  logic        thr_hit;
  logic        unused_ok;

  assign addr        = PADDR[4:0];
  assign wdata_ext   = 32'(PWDATA);
  assign is_data     = (addr == A_DATA);
  assign is_stat     = (addr == A_STAT);
  assign is_int_stat = (addr == A_INT_STAT);
  assign mapped      = (addr == A_DATA) || (addr == A_CTRL) || (addr == A_STAT) ||
                       (addr == A_INT_STAT) || (addr == A_INT_EN) || (addr == A_RX_THR);
  assign data_wr     = PWRITE & is_data;
  assign in_access   = (state == ST_ACCESS);
  assign bus_phase   = PSELx & PENABLE;

`ifdef UART_APB_STALL_TIMEOUT_EN
  logic [7:0] stall_cnt;

  // Once the counter has reached the limit the transfer is forced to end.
  assign stall_timeout = in_access & bus_phase & data_wr & full_tx_fifo &
                         (stall_cnt == 8'(STALL_TIMEOUT));
  assign stalled       = in_access & bus_phase & data_wr & full_tx_fifo & ~stall_timeout;

  // Counts consecutive stalled cycles of the current transfer only.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stall_cnt <= 8'd0;
    end else if (stalled) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= 8'd0;
    end
  end
`else
  assign stall_timeout = 1'b0;
  assign stalled       = in_access & bus_phase & data_wr & full_tx_fifo;
`endif

  assign PREADY     = ~((state == ST_WAIT) | stalled);
  // Completion is only honoured in ACCESS so a leftover enable phase after
  // reset cannot trigger a FIFO pulse or register write.
  assign completion = in_access & bus_phase & PREADY;

  assign err_cond = ~mapped |
                    (PWRITE & is_stat) |
                    (~PWRITE & is_data & empty_rx_fifo) |
                    stall_timeout;

  assign wr_ok   = completion & PWRITE & ~err_cond;
  assign rd_ok   = completion & ~PWRITE & ~err_cond;
  assign PSLVERR = completion & err_cond;

  assign wr_en_tx_fifo = wr_ok & is_data;
  assign din_tx_fifo   = wr_en_tx_fifo ? PWDATA[7:0] : 8'h00;
  assign rd_en_rx_fifo = rd_ok & is_data;

  assign stat_word = {8'h00, 8'(tx_level), 8'(rx_level), 1'b0,
                      tx_busy, tx_ready, full_tx_fifo,
                      rx_error, rx_busy, rx_ready, empty_rx_fifo};

  // Read mux; fields are built at 32 bits and truncated to the bus width.
  always_comb begin
    rdata_ext = 32'h0;
    case (addr)
      A_DATA:     rdata_ext = {24'h0, dout_rx_fifo};
      A_CTRL:     rdata_ext = {24'h0, ctrl_q};
      A_STAT:     rdata_ext = stat_word;
      A_INT_STAT: rdata_ext = {28'h0, int_stat_q};
      A_INT_EN:   rdata_ext = {28'h0, int_en_q};
      A_RX_THR:   rdata_ext = 32'(rx_thr_q);
      default:    rdata_ext = 32'h0;
    endcase
  end

  assign PRDATA = rd_ok ? rdata_ext[DATA_WIDTH-1:0] : '0;

  // Transfer sequencing: setup -> optional wait states -> access.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSELx & ~PENABLE) begin
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 3'(WAIT_CYCLES);
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (!PSELx) begin
            state <= ST_IDLE;
          end else if (wait_cnt <= 3'd1) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (completion | ~PSELx) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Software-writable registers; an errored write never reaches here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q   <= 8'h00;
      int_en_q <= 4'h0;
      rx_thr_q <= LVL_W'(1);
    end else if (wr_ok) begin
      case (addr)
        A_CTRL:   ctrl_q   <= wdata_ext[7:0];
        A_INT_EN: int_en_q <= wdata_ext[3:0];
        A_RX_THR: rx_thr_q <= wdata_ext[LVL_W-1:0];
        default:  ;
      endcase
    end
  end

  assign thr_hit = (rx_thr_q != '0) && (rx_level >= rx_thr_q);
  assign int_set = {thr_hit,
                    rx_error & ~rx_error_q,
                    tx_ready & ~tx_ready_q,
                    rx_ready & ~rx_ready_q};
  assign int_w1c = (wr_ok & is_int_stat) ? wdata_ext[3:0] : 4'h0;

  // Interrupt status: the set term is ORed after the clear so a new event
  // in the same cycle as a W1C is not lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      int_stat_q <= 4'h0;
      rx_ready_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      int_stat_q <= (int_stat_q & ~int_w1c) | int_set;
      rx_ready_q <= rx_ready;
      tx_ready_q <= tx_ready;
      rx_error_q <= rx_error;
      irq_q      <= |(int_stat_q & int_en_q);
    end
  end

  assign irq             = irq_q;
  assign en_sys          = ctrl_q[0];
  assign tx_en           = ctrl_q[1];
  assign clk_freq_index  = ctrl_q[3:2];
  assign baud_rate_index = ctrl_q[6:4];

  assign unused_ok = ^{PADDR, wdata_ext, rdata_ext, (STALL_TIMEOUT > 0)};

endmodule

// File: tb/tb_uart_apb_regs.sv
module tb_uart_apb_regs;

  logic        PCLK;
  logic        PRESETn;
  logic [4:0]  PADDR;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        full_tx_fifo;
  logic [4:0]  tx_level;
  logic        empty_rx_fifo;
  logic [4:0]  rx_level;
  logic [7:0]  dout_rx_fifo;
  logic        tx_busy, tx_ready, rx_busy, rx_ready, rx_error;

  logic        pready, pslverr, wr_en, rd_en, en_sys, tx_en, irq;
  logic [31:0] prdata;
  logic [7:0]  din;
  logic [1:0]  clk_freq;
  logic [2:0]  baud;

  logic        pready_ws, pslverr_ws, wr_en_ws, rd_en_ws, en_sys_ws, tx_en_ws, irq_ws;
  logic [31:0] prdata_ws;
  logic [7:0]  din_ws;
  logic [1:0]  clk_freq_ws;
  logic [2:0]  baud_ws;

  logic        use_ws;
  logic        sel_pready, sel_pslverr, sel_wr, sel_rd;
  logic [31:0] sel_prdata;
  logic [7:0]  sel_din;

  int vec_count  = 0;
  int miscompares = 0;

  uart_apb_regs #(.WAIT_CYCLES(0), .STALL_TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr),
    .full_tx_fifo(full_tx_fifo), .tx_level(tx_level), .empty_rx_fifo(empty_rx_fifo),
    .rx_level(rx_level), .dout_rx_fifo(dout_rx_fifo), .tx_busy(tx_busy), .tx_ready(tx_ready),
    .rx_busy(rx_busy), .rx_ready(rx_ready), .rx_error(rx_error), .din_tx_fifo(din),
    .wr_en_tx_fifo(wr_en), .rd_en_rx_fifo(rd_en), .en_sys(en_sys), .tx_en(tx_en),
    .clk_freq_index(clk_freq), .baud_rate_index(baud), .irq(irq));

  uart_apb_regs #(.WAIT_CYCLES(2)) dut_ws (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready_ws), .PRDATA(prdata_ws), .PSLVERR(pslverr_ws),
    .full_tx_fifo(full_tx_fifo), .tx_level(tx_level), .empty_rx_fifo(empty_rx_fifo),
    .rx_level(rx_level), .dout_rx_fifo(dout_rx_fifo), .tx_busy(tx_busy), .tx_ready(tx_ready),
    .rx_busy(rx_busy), .rx_ready(rx_ready), .rx_error(rx_error), .din_tx_fifo(din_ws),
    .wr_en_tx_fifo(wr_en_ws), .rd_en_rx_fifo(rd_en_ws), .en_sys(en_sys_ws), .tx_en(tx_en_ws),
    .clk_freq_index(clk_freq_ws), .baud_rate_index(baud_ws), .irq(irq_ws));

  assign sel_pready  = use_ws ? pready_ws  : pready;
  assign sel_pslverr = use_ws ? pslverr_ws : pslverr;
  assign sel_prdata  = use_ws ? prdata_ws  : prdata;
  assign sel_wr      = use_ws ? wr_en_ws   : wr_en;
  assign sel_rd      = use_ws ? rd_en_ws   : rd_en;
  assign sel_din     = use_ws ? din_ws     : din;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One APB transfer; returns what was observed, the test tasks judge it.
  task automatic apb_xfer(input logic [4:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic ws, input int release_at, input logic rx_ready_hit,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output int wr_pulses, output int rd_pulses, output logic [7:0] dout);
    int  k;
    logic done;
    use_ws = ws;
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    waits = 0; wr_pulses = 0; rd_pulses = 0; rdata = 32'h0; err = 1'b0; dout = 8'h00;
    done = 1'b0; k = 0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    if (rx_ready_hit) rx_ready = 1'b1;
    while (!done && k < 64) begin
      if (k == release_at) full_tx_fifo = 1'b0;
      #1;
      wr_pulses += int'(sel_wr);
      rd_pulses += int'(sel_rd);
      if (sel_pready) begin
        rdata = sel_prdata; err = sel_pslverr; dout = sel_din; done = 1'b1;
      end else begin
        waits++;
        k++;
        @(negedge PCLK);
      end
    end
    vec_count++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL xfer_timeout addr=%h: PREADY never rose within 64 cycles", addr);
    end
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    vec_count++; if (pready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pready: got %b want 1", pready); end
    vec_count++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_resp: prdata=%h pslverr=%b want 0/0", prdata, pslverr); end
    vec_count++; if ({irq, wr_en, rd_en, din} !== 11'h0) begin miscompares++; $display("[TB] FAIL rst_outs: irq=%b wr=%b rd=%b din=%h want 0", irq, wr_en, rd_en, din); end
    vec_count++; if ({en_sys, tx_en, clk_freq, baud} !== 7'h0) begin miscompares++; $display("[TB] FAIL rst_ctrl: got %b want 0", {en_sys, tx_en, clk_freq, baud}); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(5'h04, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ctrl_rd: got %h err=%b want 0", rd, er); end
    apb_xfer(5'h14, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL rst_rxthr_rd: got %h want 1", rd); end
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_intstat_rd: got %h want 0", rd); end
    apb_xfer(5'h10, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_inten_rd: got %h want 0", rd); end
    bus_idle();
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    apb_xfer(5'h04, 1'b1, 32'hD5, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (er !== 1'b0 || w != 0) begin miscompares++; $display("[TB] FAIL ctrl_wr: err=%b waits=%0d want 0/0", er, w); end
    bus_idle();
    vec_count++; if ({en_sys, tx_en, clk_freq, baud} !== {1'b1, 1'b0, 2'd1, 3'd5}) begin
      miscompares++; $display("[TB] FAIL ctrl_outs: en=%b tx_en=%b clk=%0d baud=%0d want 1/0/1/5", en_sys, tx_en, clk_freq, baud); end
    apb_xfer(5'h04, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'hD5 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL ctrl_rd: got %h err=%b want d5/0", rd, er); end
    bus_idle();
    vec_count++; if (prdata !== 32'h0) begin miscompares++; $display("[TB] FAIL prdata_idle: got %h want 0", prdata); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    repeat (3) bus_idle();
    empty_rx_fifo = 1'b1; rx_ready = 1'b0; rx_busy = 1'b1; rx_error = 1'b0;
    full_tx_fifo = 1'b0; tx_ready = 1'b1; tx_busy = 1'b0;
    rx_level = 5'h0A; tx_level = 5'h13;
    apb_xfer(5'h08, 1'b0, 32'h0, 1'b1, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (w != 2) begin miscompares++; $display("[TB] FAIL ws_stat_waits: got %0d want 2", w); end
    vec_count++; if (rd !== 32'h00130A25 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL ws_stat_rd: got %h err=%b want 00130a25/0", rd, er); end
    apb_xfer(5'h04, 1'b1, 32'h2A, 1'b1, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (er !== 1'b0 || w != 2) begin miscompares++; $display("[TB] FAIL ws_ctrl_wr: err=%b waits=%0d want 0/2", er, w); end
    apb_xfer(5'h08, 1'b1, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (er !== 1'b1 || w != 2) begin miscompares++; $display("[TB] FAIL ws_stat_wr_err: err=%b waits=%0d want 1/2", er, w); end
    apb_xfer(5'h04, 1'b0, 32'h0, 1'b1, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h2A) begin miscompares++; $display("[TB] FAIL ws_nochange: got %h want 2a", rd); end
    repeat (3) bus_idle();
    apb_xfer(5'h18, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped_rd: err=%b data=%h want 1/0", er, rd); end
    bus_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    apb_xfer(5'h00, 1'b1, 32'h5A, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (w != 0 || wp != 1 || dn !== 8'h5A || er !== 1'b0) begin
      miscompares++; $display("[TB] FAIL push_free: waits=%0d pulses=%0d din=%h err=%b want 0/1/5a/0", w, wp, dn, er); end
    bus_idle();
    full_tx_fifo = 1'b1;
`ifdef UART_APB_STALL_TIMEOUT_EN
    apb_xfer(5'h00, 1'b1, 32'h3C, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (w != 4 || er !== 1'b1 || wp != 0) begin
      miscompares++; $display("[TB] FAIL stall_timeout: waits=%0d err=%b pulses=%0d want 4/1/0", w, er, wp); end
    full_tx_fifo = 1'b0;
`else
    apb_xfer(5'h00, 1'b1, 32'h3C, 1'b0, 5, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (w != 5) begin miscompares++; $display("[TB] FAIL stall_waits: got %0d want 5", w); end
    vec_count++; if (wp != 1 || dn !== 8'h3C || er !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall_push: pulses=%0d din=%h err=%b want 1/3c/0", wp, dn, er); end
`endif
    bus_idle();
    vec_count++; if (wr_en !== 1'b0 || din !== 8'h00) begin miscompares++; $display("[TB] FAIL push_after: wr=%b din=%h want 0/00", wr_en, din); end
  endtask

  task automatic test_rx_read();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    empty_rx_fifo = 1'b1; dout_rx_fifo = 8'h55;
    apb_xfer(5'h00, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0 || er !== 1'b1 || rp != 0) begin
      miscompares++; $display("[TB] FAIL empty_rd: data=%h err=%b pops=%0d want 0/1/0", rd, er, rp); end
    bus_idle();
    empty_rx_fifo = 1'b0; dout_rx_fifo = 8'hA7;
    apb_xfer(5'h00, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'hA7 || er !== 1'b0 || rp != 1) begin
      miscompares++; $display("[TB] FAIL pop_rd: data=%h err=%b pops=%0d want a7/0/1", rd, er, rp); end
    bus_idle();
    vec_count++; if (rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL pop_after: rd_en=%b want 0", rd_en); end
    empty_rx_fifo = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    apb_xfer(5'h04, 1'b1, 32'h03, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h04, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h03 || w != 0) begin miscompares++; $display("[TB] FAIL b2b_rd: data=%h waits=%0d want 03/0", rd, w); end
    apb_xfer(5'h10, 1'b1, 32'h6, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h10, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h6) begin miscompares++; $display("[TB] FAIL b2b_inten: data=%h want 6", rd); end
    bus_idle();
  endtask

  task automatic test_interrupts();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    rx_level = 5'd0; tx_level = 5'd0; tx_ready = 1'b0; rx_ready = 1'b0; rx_error = 1'b0; rx_busy = 1'b0;
    apb_xfer(5'h10, 1'b1, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b1, 32'hF, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL int_clear: got %h want 0", rd); end
    apb_xfer(5'h14, 1'b1, 32'h3, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h10, 1'b1, 32'h9, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h14, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h3) begin miscompares++; $display("[TB] FAIL rxthr_rd: got %h want 3", rd); end
    bus_idle();
    rx_level = 5'd2;
    bus_idle();
    rx_level = 5'd3;
    #1;
    vec_count++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_pre: got %b want 0", irq); end
    @(negedge PCLK); #1;
    vec_count++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_lat: got %b want 0", irq); end
    @(negedge PCLK); #1;
    vec_count++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_set: got %b want 1", irq); end
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h8) begin miscompares++; $display("[TB] FAIL thr_stat: got %h want 8", rd); end
    apb_xfer(5'h0C, 1'b1, 32'h8, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h8 || irq !== 1'b1) begin miscompares++; $display("[TB] FAIL thr_sticky: stat=%h irq=%b want 8/1", rd, irq); end
    bus_idle();
    rx_level = 5'd2;
    apb_xfer(5'h0C, 1'b1, 32'h8, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("[TB] FAIL thr_clear: stat=%h irq=%b want 0/0", rd, irq); end
    bus_idle();
  endtask

  task automatic test_edges();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    tx_ready = 1'b1;
    repeat (10) @(negedge PCLK);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h2 || irq !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_edge: stat=%h irq=%b want 2/0", rd, irq); end
    apb_xfer(5'h0C, 1'b1, 32'h2, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL tx_level_once: stat=%h want 0", rd); end
    bus_idle();
    tx_ready = 1'b0; rx_ready = 1'b1;
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h1 || irq !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_edge: stat=%h irq=%b want 1/1", rd, irq); end
    bus_idle();
    rx_ready = 1'b0;
    apb_xfer(5'h0C, 1'b1, 32'h1, 1'b0, -1, 1'b1, rd, er, w, wp, rp, dn);
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL w1c_race: stat=%h want 1", rd); end
    apb_xfer(5'h0C, 1'b1, 32'h1, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    bus_idle();
    rx_error = 1'b1;
    apb_xfer(5'h0C, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h4) begin miscompares++; $display("[TB] FAIL rxerr_edge: stat=%h want 4", rd); end
    bus_idle();
    rx_error = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd; logic er; int w, wp, rp; logic [7:0] dn;
    apb_xfer(5'h04, 1'b1, 32'h55, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    bus_idle();
    full_tx_fifo = 1'b1;
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 5'h00; PWRITE = 1'b1; PWDATA = 32'h77; use_ws = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    vec_count++; if (pready !== 1'b0 || en_sys !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_stall: pready=%b en=%b want 0/1", pready, en_sys); end
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    vec_count++; if (pready !== 1'b1 || wr_en !== 1'b0 || en_sys !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_reset: pready=%b wr=%b en=%b want 1/0/0", pready, wr_en, en_sys); end
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; full_tx_fifo = 1'b0; PRESETn = 1'b1;
    apb_xfer(5'h04, 1'b0, 32'h0, 1'b0, -1, 1'b0, rd, er, w, wp, rp, dn);
    vec_count++; if (rd !== 32'h0 || w != 0 || wp != 0) begin
      miscompares++; $display("[TB] FAIL post_reset_rd: data=%h waits=%0d pushes=%0d want 0/0/0", rd, w, wp); end
    bus_idle();
  endtask

  initial begin
    PRESETn = 1'b0; PADDR = 5'h0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 32'h0;
    full_tx_fifo = 1'b0; tx_level = 5'h0; empty_rx_fifo = 1'b1; rx_level = 5'h0; dout_rx_fifo = 8'h0;
    tx_busy = 1'b0; tx_ready = 1'b0; rx_busy = 1'b0; rx_ready = 1'b0; rx_error = 1'b0; use_ws = 1'b0;
    test_reset();
    test_ctrl();
    test_wait_states();
    test_backpressure();
    test_rx_read();
    test_back_to_back();
    test_interrupts();
    test_edges();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
